drm_stream_mux: RTL and testbench

DRM_STREAM_MUX -- requirements
Module: drm_stream_mux

---
 rtl/drm_stream_mux.sv | 206 ++++++++++++++++++++
 tb/tb_drm_stream_mux.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drm_stream_mux.sv
// drm_stream_mux: bridges one DRM-controller AXI4-Stream pair to N user-IP
// activator channels.
//   Downstream: packets on s_drm_* are routed to one m_uip_* channel chosen by
//     the low C_ID_WIDTH bits of the first beat; unknown IDs are consumed and
//     counted in drop_count (saturating).
//   Upstream: packets on s_uip_* are merged onto m_drm_* by a packet-locked
//     round-robin arbiter; grant_id reports the channel currently granted.
// Ports:
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   s_drm_*                     controller -> block stream
//   m_uip_* [N]                 block -> user-IP streams (tdata/tlast broadcast)
//   s_uip_* [N]                 user-IP -> block streams
//   m_drm_*                     block -> controller merged stream
//   drop_count                  dropped downstream packets, saturating
//   grant_id                    upstream channel currently granted
module drm_stream_mux #(
  parameter int unsigned C_NUM_CHANNELS = 4,
  parameter int unsigned C_DATA_WIDTH   = 32,
  parameter int unsigned C_ID_WIDTH     = 3
) (
  input  logic                                     ap_clk,
  input  logic                                     ap_rst_n,
  input  logic                                     s_drm_tvalid,
  output logic                                     s_drm_tready,
  input  logic [C_DATA_WIDTH-1:0]                  s_drm_tdata,
  input  logic                                     s_drm_tlast,
  output logic [C_NUM_CHANNELS-1:0]                m_uip_tvalid,
  input  logic [C_NUM_CHANNELS-1:0]                m_uip_tready,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]   m_uip_tdata,
  output logic [C_NUM_CHANNELS-1:0]                m_uip_tlast,
  input  logic [C_NUM_CHANNELS-1:0]                s_uip_tvalid,
  output logic [C_NUM_CHANNELS-1:0]                s_uip_tready,
  input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0]   s_uip_tdata,
  input  logic [C_NUM_CHANNELS-1:0]                s_uip_tlast,
  output logic                                     m_drm_tvalid,
  input  logic                                     m_drm_tready,
  output logic [C_DATA_WIDTH-1:0]                  m_drm_tdata,
  output logic                                     m_drm_tlast,
  output logic [15:0]                              drop_count,
  output logic [C_ID_WIDTH-1:0]                    grant_id
);

  localparam int unsigned N  = C_NUM_CHANNELS;
  localparam int unsigned W  = C_DATA_WIDTH;
  localparam int unsigned IW = C_ID_WIDTH;
  localparam logic [IW:0]   NUM_IDS   = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_CHAN = IW'(N - 1);
  localparam logic [15:0]   DROP_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {D_IDLE, D_ROUTE, D_DROP} d_state_t;
  typedef enum logic       {U_ARB, U_LOCK}           u_state_t;

  // ------------------------------------------------------------------
  // Downstream router
  // ------------------------------------------------------------------
  d_state_t        d_state, d_next;
  logic [IW-1:0]   hdr_id, route_id, ds_sel;
  logic            hdr_ok, ds_hs, hdr_drop;

  // Header decode; only meaningful on the first beat (D_IDLE)
  always_comb begin
    hdr_id   = s_drm_tdata[IW-1:0];
    hdr_ok   = ({1'b0, hdr_id} < NUM_IDS);
    ds_sel   = (d_state == D_ROUTE) ? route_id : hdr_id;
    ds_hs    = s_drm_tvalid && s_drm_tready;
    hdr_drop = (d_state == D_IDLE) && ds_hs && !hdr_ok;
  end

  // State register and latched route
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      d_state  <= D_IDLE;
      route_id <= '0;
    end else begin
      d_state <= d_next;
      if (d_state == D_IDLE && ds_hs && hdr_ok) route_id <= hdr_id;
    end
  end

  // Next-state
  always_comb begin
    d_next = d_state;
    unique case (d_state)
      D_IDLE:  if (ds_hs && !s_drm_tlast) d_next = hdr_ok ? D_ROUTE : D_DROP;
      D_ROUTE: if (ds_hs && s_drm_tlast)  d_next = D_IDLE;
      D_DROP:  if (ds_hs && s_drm_tlast)  d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // Outputs: zero-latency steering; the reset gate keeps handshakes quiet
  // even while a source is still presenting a beat.
  always_comb begin
    m_uip_tvalid = '0;
    s_drm_tready = 1'b0;
    unique case (d_state)
      D_IDLE, D_ROUTE: begin
        if (d_state == D_ROUTE || hdr_ok) begin
          for (int k = 0; k < N; k++) begin
            if (ds_sel == IW'(k)) begin
              m_uip_tvalid[k] = s_drm_tvalid;
              s_drm_tready    = m_uip_tready[k];
            end
          end
        end else begin
          s_drm_tready = 1'b1;
        end
      end
      D_DROP:  s_drm_tready = 1'b1;
      default: s_drm_tready = 1'b0;
    endcase
    if (!ap_rst_n) begin
      m_uip_tvalid = '0;
      s_drm_tready = 1'b0;
    end
  end

  assign m_uip_tdata = {N{s_drm_tdata}};
  assign m_uip_tlast = {N{s_drm_tlast}};

  // Dropped-packet counter, counted on the header beat only
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_count <= '0;
    end else if (hdr_drop && drop_count != DROP_MAX) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // ------------------------------------------------------------------
  // Upstream arbiter
  // ------------------------------------------------------------------
  u_state_t        u_state, u_next;
  logic [IW-1:0]   last_grant, rr_grant, hi_id, lo_id;
  logic            rr_valid, hi_hit, lo_hit, us_hs;

  // Round-robin pick: lowest requester above last_grant, else lowest overall
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int k = 0; k < N; k++) begin
      if (s_uip_tvalid[k]) begin
        if (IW'(k) > last_grant) begin
          if (!hi_hit) begin
            hi_hit = 1'b1;
            hi_id  = IW'(k);
          end
        end else if (!lo_hit) begin
          lo_hit = 1'b1;
          lo_id  = IW'(k);
        end
      end
    end
    rr_valid = hi_hit || lo_hit;
    rr_grant = hi_hit ? hi_id : lo_id;
  end

  // State register, grant and round-robin pointer
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      u_state    <= U_ARB;
      grant_id   <= '0;
      last_grant <= LAST_CHAN;
    end else begin
      u_state <= u_next;
      if (u_state == U_ARB && rr_valid) grant_id <= rr_grant;
      if (u_state == U_LOCK && us_hs && m_drm_tlast) last_grant <= grant_id;
    end
  end

  // Next-state: grant is held until the packet's last beat is accepted
  always_comb begin
    u_next = u_state;
    unique case (u_state)
      U_ARB:   if (rr_valid) u_next = U_LOCK;
      U_LOCK:  if (us_hs && m_drm_tlast) u_next = U_ARB;
      default: u_next = U_ARB;
    endcase
  end

  // Outputs: pass-through of the granted channel while locked
  always_comb begin
    m_drm_tvalid = 1'b0;
    m_drm_tdata  = '0;
    m_drm_tlast  = 1'b0;
    s_uip_tready = '0;
    if (u_state == U_LOCK) begin
      for (int k = 0; k < N; k++) begin
        if (grant_id == IW'(k)) begin
          m_drm_tvalid    = s_uip_tvalid[k];
          m_drm_tdata     = s_uip_tdata[k*W +: W];
          m_drm_tlast     = s_uip_tlast[k];
          s_uip_tready[k] = m_drm_tready;
        end
      end
    end
    if (!ap_rst_n) begin
      m_drm_tvalid = 1'b0;
      s_uip_tready = '0;
    end
    us_hs = m_drm_tvalid && m_drm_tready;
  end

endmodule

// File: tb/tb_drm_stream_mux.sv
// Randomized bench for drm_stream_mux (N=4, 32-bit, 3-bit IDs) against a
// packet-level reference: per-channel beat queues, a round-robin pick over the
// channels requesting when the arbiter is free, and a saturating drop tally.
module tb_drm_stream_mux;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 3;
  localparam int CW = 2;

  logic             ap_clk, ap_rst_n;
  logic             s_drm_tvalid, s_drm_tready, s_drm_tlast;
  logic [W-1:0]     s_drm_tdata;
  logic [N-1:0]     m_uip_tvalid, m_uip_tready, m_uip_tlast;
  logic [N*W-1:0]   m_uip_tdata;
  logic [N-1:0]     s_uip_tvalid, s_uip_tready, s_uip_tlast;
  logic [N*W-1:0]   s_uip_tdata;
  logic             m_drm_tvalid, m_drm_tready, m_drm_tlast;
  logic [W-1:0]     m_drm_tdata;
  logic [15:0]      drop_count;
  logic [IW-1:0]    grant_id;
  logic [W-1:0]     us_data [N];

  drm_stream_mux #(.C_NUM_CHANNELS(N), .C_DATA_WIDTH(W), .C_ID_WIDTH(IW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_drm_tvalid(s_drm_tvalid), .s_drm_tready(s_drm_tready),
    .s_drm_tdata(s_drm_tdata), .s_drm_tlast(s_drm_tlast),
    .m_uip_tvalid(m_uip_tvalid), .m_uip_tready(m_uip_tready),
    .m_uip_tdata(m_uip_tdata), .m_uip_tlast(m_uip_tlast),
    .s_uip_tvalid(s_uip_tvalid), .s_uip_tready(s_uip_tready),
    .s_uip_tdata(s_uip_tdata), .s_uip_tlast(s_uip_tlast),
    .m_drm_tvalid(m_drm_tvalid), .m_drm_tready(m_drm_tready),
    .m_drm_tdata(m_drm_tdata), .m_drm_tlast(m_drm_tlast),
    .drop_count(drop_count), .grant_id(grant_id)
  );

  for (genvar g = 0; g < N; g++) begin : g_us
    assign s_uip_tdata[g*W +: W] = us_data[g];
  end

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           id;
    logic         first;
  } beat_t;

  beat_t        ds_q[$];
  beat_t        us_q [N][$];
  int           n_vec = 0;
  int           n_err = 0;
  int           exp_drops, u_grant, u_last;
  bit           u_locked, ds_hs;
  bit [N-1:0]   us_hs, us_auto;
  int           glog[$];
  int           ds_deliv [N];
  int           ds_rate, ds_auto, uip_ready_pct, drm_ready_pct, us_gap_pct, us_len;
  int           exp_order [6] = '{0, 1, 3, 0, 1, 3};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(input int pct);
    int r;
    r = int'($urandom_range(99, 0));
    return r < pct;
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (last + i) % N;
      if (req[CW'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic ds_add_pkt(input int id, input int len);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.data  = $urandom;
      if (b == 0) x.data[IW-1:0] = IW'(id);
      x.last  = (b == len - 1);
      x.id    = id;
      x.first = (b == 0);
      ds_q.push_back(x);
    end
  endtask

  task automatic us_add_pkt(input int k, input int len);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.data  = $urandom;
      x.last  = (b == len - 1);
      x.id    = k;
      x.first = (b == 0);
      us_q[CW'(k)].push_back(x);
    end
  endtask

  task automatic model_clear();
    ds_q.delete();
    for (int i = 0; i < N; i++) begin
      us_q[CW'(i)].delete();
      ds_deliv[CW'(i)] = 0;
      us_data[CW'(i)]  = '0;
    end
    exp_drops = 0; u_locked = 0; u_grant = 0; u_last = N - 1;
    ds_hs = 0; us_hs = '0; glog.delete();
    s_drm_tvalid = 0; s_drm_tlast = 0; s_drm_tdata = '0;
    s_uip_tvalid = '0; s_uip_tlast = '0;
    m_uip_tready = '0; m_drm_tready = 0;
  endtask

  // Apply last cycle's handshakes, then present this cycle's stimulus
  task automatic drive();
    bit keep;
    int len;
    logic [CW-1:0] c;
    keep = s_drm_tvalid && !ds_hs;
    if (ds_hs) void'(ds_q.pop_front());
    ds_hs = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = CW'(i);
      if (us_hs[c]) void'(us_q[c].pop_front());
    end
    us_hs = '0;
    if (ds_q.size() == 0 && ds_auto > 0 && hit(ds_auto))
      ds_add_pkt(int'($urandom_range(7, 0)), int'($urandom_range(4, 1)));
    if (ds_q.size() != 0) begin
      if (!keep) s_drm_tvalid = hit(ds_rate);
      s_drm_tdata = ds_q[0].data;
      s_drm_tlast = ds_q[0].last;
    end else begin
      s_drm_tvalid = 1'b0;
      s_drm_tdata  = $urandom;
      s_drm_tlast  = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      c = CW'(i);
      m_uip_tready[c] = hit(uip_ready_pct);
      if (us_q[c].size() == 0 && us_auto[c] && !hit(us_gap_pct)) begin
        len = (us_len > 0) ? us_len : int'($urandom_range(3, 1));
        us_add_pkt(i, len);
      end
      if (us_q[c].size() != 0) begin
        s_uip_tvalid[c] = 1'b1;
        us_data[c]      = us_q[c][0].data;
        s_uip_tlast[c]  = us_q[c][0].last;
      end else begin
        s_uip_tvalid[c] = 1'b0;
        us_data[c]      = $urandom;
        s_uip_tlast[c]  = 1'b0;
      end
    end
    m_drm_tready = hit(drm_ready_pct);
  endtask

  // Compare DUT outputs against the reference for the current cycle
  task automatic check_cycle();
    beat_t         f;
    bit            routed;
    logic [CW-1:0] c, g;
    logic [N-1:0]  expv;
    chk("drop_count", 128'(drop_count), 128'(exp_drops));
    chk("grant_id", 128'(grant_id), 128'(u_grant));
    chk("ds_bcast_data", 128'(m_uip_tdata), 128'({N{s_drm_tdata}}));
    chk("ds_bcast_last", 128'(m_uip_tlast), 128'({N{s_drm_tlast}}));
    if (s_drm_tvalid) begin
      f      = ds_q[0];
      routed = (f.id < N);
      expv   = '0;
      c      = CW'(f.id);
      if (routed) begin
        expv[c] = 1'b1;
        chk("ds_tready_route", 128'(s_drm_tready), 128'(m_uip_tready[c]));
      end else begin
        chk("ds_tready_drop", 128'(s_drm_tready), 128'(1));
      end
      chk("ds_tvalid", 128'(m_uip_tvalid), 128'(expv));
      ds_hs = s_drm_tready;
      if (ds_hs) begin
        if (routed) ds_deliv[c]++;
        else if (f.first && exp_drops < 65535) exp_drops++;
      end
    end else begin
      chk("ds_tvalid_idle", 128'(m_uip_tvalid), 128'(0));
    end
    if (!u_locked) begin
      chk("us_tvalid_arb", 128'(m_drm_tvalid), 128'(0));
      chk("us_tready_arb", 128'(s_uip_tready), 128'(0));
      if (|s_uip_tvalid) begin
        u_grant  = rr_pick(u_last, s_uip_tvalid);
        u_locked = 1'b1;
      end
    end else begin
      g    = CW'(u_grant);
      expv = '0;
      expv[g] = m_drm_tready;
      chk("us_tvalid", 128'(m_drm_tvalid), 128'(s_uip_tvalid[g]));
      chk("us_tready", 128'(s_uip_tready), 128'(expv));
      if (s_uip_tvalid[g]) begin
        chk("us_tdata", 128'(m_drm_tdata), 128'(us_q[g][0].data));
        chk("us_tlast", 128'(m_drm_tlast), 128'(us_q[g][0].last));
        if (m_drm_tready) begin
          us_hs[g] = 1'b1;
          if (us_q[g][0].first) glog.push_back(u_grant);
          if (us_q[g][0].last) begin
            u_locked = 1'b0;
            u_last   = u_grant;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
    drive();
    @(negedge ap_clk);
    check_cycle();
  endtask

  task automatic rst_outputs_check(input string tag);
    chk({tag, "_m_uip_tvalid"}, 128'(m_uip_tvalid), 128'(0));
    chk({tag, "_s_drm_tready"}, 128'(s_drm_tready), 128'(0));
    chk({tag, "_m_drm_tvalid"}, 128'(m_drm_tvalid), 128'(0));
    chk({tag, "_s_uip_tready"}, 128'(s_uip_tready), 128'(0));
    chk({tag, "_drop_count"},   128'(drop_count),   128'(0));
    chk({tag, "_grant_id"},     128'(grant_id),     128'(0));
  endtask

  initial begin
    ap_rst_n = 1'b0;
    model_clear();
    ds_rate = 100; ds_auto = 0; uip_ready_pct = 100; drm_ready_pct = 100;
    us_gap_pct = 0; us_len = 2; us_auto = '0;
    // Reset with sources active: handshakes must stay low
    s_drm_tvalid = 1'b1; s_drm_tdata = 32'h1; s_uip_tvalid = '1;
    m_uip_tready = '1;   m_drm_tready = 1'b1;
    #3;
    rst_outputs_check("rst_init");
    model_clear();
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // 3-beat packet to channel 2; channels 0,1,3 stream 2-beat packets
    ds_add_pkt(2, 3);
    us_auto = 4'b1011;
    repeat (24) step();
    chk("req028_ch2_beats", 128'(ds_deliv[2]), 128'(3));
    for (int i = 0; i < N; i++)
      if (i != 2) chk("req028_other_beats", 128'(ds_deliv[CW'(i)]), 128'(0));
    for (int i = 0; i < 6; i++)
      chk("req030_order", 128'((i < glog.size()) ? glog[i] : -1), 128'(exp_order[i]));
    us_auto = '0;
    repeat (10) step();

    // Random traffic, backpressure toggling on every port
    glog.delete();
    ds_auto = 40; ds_rate = 70; uip_ready_pct = 60; drm_ready_pct = 50;
    us_auto = '1; us_len = 0; us_gap_pct = 30;
    repeat (3000) step();

    // Drain, then reset in the middle of packets on both paths
    ds_auto = 0; us_auto = '0; ds_rate = 100; uip_ready_pct = 100; drm_ready_pct = 100;
    repeat (30) step();
    ds_add_pkt(2, 6);
    us_add_pkt(1, 6);
    repeat (3) step();
    chk("rst_pre_m_uip_tvalid", 128'(m_uip_tvalid), 128'(4'b0100));
    chk("rst_pre_m_drm_tvalid", 128'(m_drm_tvalid), 128'(1));
    #2;
    ap_rst_n = 1'b0;
    #1;
    rst_outputs_check("rst_mid");
    model_clear();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    ds_add_pkt(0, 2);
    us_add_pkt(0, 1);
    us_add_pkt(2, 1);
    repeat (8) step();
    chk("post_rst_ch0_beats", 128'(ds_deliv[0]), 128'(2));
    chk("post_rst_first_grant", 128'((glog.size() > 0) ? glog[0] : -1), 128'(0));

    // Unknown-ID packet, then drop counter saturation
    ds_add_pkt(5, 4);
    repeat (6) step();
    chk("req029_one_drop", 128'(drop_count), 128'(1));
    for (int i = 0; i < 65540; i++) ds_add_pkt(4 + int'($urandom_range(3, 0)), 1);
    repeat (65545) step();
    chk("drop_saturate", 128'(drop_count), 128'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
